// File: rtl/systolic_array_ctrl.sv
// Sequencer for an N x N output-stationary systolic array.
// It streams one A column-slice and one B row-slice per cycle, applies a
// diagonal skew to both, clears the PE accumulators and reports completion.
// Optional feature macro: SYSTOLIC_PERF_CNT_EN. When it is defined, a
// saturating count of busy cycles is reported on perf_cycles.

// One skew lane: a capture register followed by DEPTH-1 delay stages.
// Cycles without a valid read return are loaded as zero.
module systolic_skew_lane #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DEPTH-1:0][DW-1:0] sr_q, sr_d;

  // capture gated data, then shift it down the lane
  always_comb begin
    sr_d    = '0;
    sr_d[0] = vld ? din : '0;
    for (int s = 1; s < DEPTH; s++) sr_d[s] = sr_q[s-1];
  end

  // lane registers, flushed to zero on reset
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign dout = sr_q[DEPTH-1];
endmodule

module systolic_array_ctrl #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [KW-1:0]   rd_addr,
  input  logic [N*DW-1:0] a_rd_data,
  input  logic [N*DW-1:0] b_rd_data,
  output logic [N*DW-1:0] pe_a,
  output logic [N*DW-1:0] pe_b,
  output logic            pe_clr,
  output logic [15:0]     perf_cycles
);
  localparam int DCW = $clog2(2*N) + 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   kcnt_q, kcnt_d;      // slices still to read after the current one
  logic [DCW-1:0]  dcnt_q, dcnt_d;      // drain cycles left
  logic [KW-1:0]   rd_addr_q, rd_addr_d;
  logic            busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic            rd_vld_q;            // read data is on the buffer outputs this cycle

  // next-state logic; registered outputs are derived from the next state
  always_comb begin
    state_d   = state_q;
    kcnt_d    = kcnt_q;
    dcnt_d    = dcnt_q;
    rd_addr_d = '0;
    case (state_q)
      S_IDLE: if (start) begin
        kcnt_d  = k_len;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (kcnt_q == '0) state_d = S_DONE;
        else begin
          kcnt_d  = kcnt_q - 1'b1;
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        if (kcnt_q == '0) begin
          dcnt_d  = DCW'(2*N - 1);
          state_d = S_DRAIN;
        end else begin
          kcnt_d    = kcnt_q - 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == '0) state_d = S_DONE;
        else              dcnt_d  = dcnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    rd_en_d = (state_d == S_FEED);
  end

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      kcnt_q    <= '0;
      dcnt_q    <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      kcnt_q    <= kcnt_d;
      dcnt_q    <= dcnt_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_vld_q  <= rd_en_q;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign pe_clr  = rst | (state_q == S_CLEAR);

  // lane i is delayed by i stages past its capture register
  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_skew_lane #(.DW(DW), .DEPTH(i+1)) u_a (
      .clk(clk), .rst(rst), .vld(rd_vld_q),
      .din(a_rd_data[i*DW +: DW]), .dout(pe_a[i*DW +: DW]));
    systolic_skew_lane #(.DW(DW), .DEPTH(i+1)) u_b (
      .clk(clk), .rst(rst), .vld(rd_vld_q),
      .din(b_rd_data[i*DW +: DW]), .dout(pe_b[i*DW +: DW]));
  end

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d, perf_q, perf_d;

  // saturating busy counter; its total is published in the DONE cycle
  always_comb begin
    cyc_d  = cyc_q;
    perf_d = perf_q;
    if (busy_q && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
    if (state_q == S_DONE) begin
      perf_d = cyc_d;
      cyc_d  = '0;
    end
  end

  // performance registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      perf_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 16'd0;
`endif
endmodule
